// File: rtl/axi_dram_pattern_master.sv
// AXI4 initiator: fills a DRAM region with (seed ^ beat address) in fixed-length INCR bursts,
// then optionally reads the region back and counts mismatching beats.
module axi_dram_pattern_master #(
    parameter int unsigned AxiAddrWidth = 64,
    parameter int unsigned AxiDataWidth = 64,
    parameter int unsigned AxiIdWidth   = 5,
    parameter int unsigned BurstLen     = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_i,
    input  logic                        verify_i,
    input  logic [AxiAddrWidth-1:0]     base_addr_i,
    input  logic [31:0]                 num_bursts_i,
    input  logic [AxiDataWidth-1:0]     seed_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        error_o,
    output logic [31:0]                 err_count_o,
    output logic [AxiAddrWidth-1:0]     first_err_addr_o,
    output logic [AxiIdWidth-1:0]       aw_id_o,
    output logic [AxiAddrWidth-1:0]     aw_addr_o,
    output logic [7:0]                  aw_len_o,
    output logic [2:0]                  aw_size_o,
    output logic [1:0]                  aw_burst_o,
    output logic                        aw_valid_o,
    input  logic                        aw_ready_i,
    output logic [AxiDataWidth-1:0]     w_data_o,
    output logic [AxiDataWidth/8-1:0]   w_strb_o,
    output logic                        w_last_o,
    output logic                        w_valid_o,
    input  logic                        w_ready_i,
    input  logic [1:0]                  b_resp_i,
    input  logic                        b_valid_i,
    output logic                        b_ready_o,
    output logic [AxiIdWidth-1:0]       ar_id_o,
    output logic [AxiAddrWidth-1:0]     ar_addr_o,
    output logic [7:0]                  ar_len_o,
    output logic [2:0]                  ar_size_o,
    output logic [1:0]                  ar_burst_o,
    output logic                        ar_valid_o,
    input  logic                        ar_ready_i,
    input  logic [AxiDataWidth-1:0]     r_data_i,
    input  logic [1:0]                  r_resp_i,
    input  logic                        r_last_i,
    input  logic                        r_valid_i,
    output logic                        r_ready_o
);
    localparam int unsigned DataBytes  = AxiDataWidth / 8;
    localparam int unsigned BurstBytes = BurstLen * DataBytes;
    localparam int unsigned SizeLog2   = $clog2(DataBytes);
    localparam int unsigned OffW       = $clog2(BurstBytes);
    localparam logic [AxiAddrWidth-1:0] OffMask  = (AxiAddrWidth'(1) << OffW) - AxiAddrWidth'(1);
    localparam logic [8:0]              LastBeat = 9'(BurstLen - 1);
    localparam logic [1:0]              RespOkay = 2'b00;

    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, FINISH} state_e;

    state_e                  state_q, state_d;
    logic                    busy_q;
    logic [31:0]             burst_q, burst_d;
    logic [8:0]              beat_q, beat_d;
    logic [AxiAddrWidth-1:0] addr_q, addr_d;
    logic [AxiAddrWidth-1:0] base_q;
    logic [31:0]             num_q;
    logic [AxiDataWidth-1:0] seed_q;
    logic                    verify_q;
    logic                    error_q;
    logic [31:0]             err_cnt_q;
    logic [AxiAddrWidth-1:0] first_err_q;

    logic                    start_acc;
    logic                    err_hit;
    logic [AxiAddrWidth-1:0] err_addr;
    logic [AxiAddrWidth-1:0] beat_addr;
    logic                    last_burst;

    function automatic logic [AxiDataWidth-1:0] pattern(input logic [AxiDataWidth-1:0] seed,
                                                        input logic [AxiAddrWidth-1:0] addr);
        logic [AxiDataWidth-1:0] ext;
        ext = '0;
        for (int i = 0; i < AxiAddrWidth && i < AxiDataWidth; i++) ext[i] = addr[i];
        return seed ^ ext;
    endfunction

    assign beat_addr  = addr_q + (AxiAddrWidth'(beat_q) << SizeLog2);
    assign last_burst = (burst_q + 32'd1) == num_q;

    always_comb begin
        state_d   = state_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        addr_d    = addr_q;
        start_acc = 1'b0;
        err_hit   = 1'b0;
        err_addr  = beat_addr;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    start_acc = 1'b1;
                    burst_d   = '0;
                    beat_d    = '0;
                    addr_d    = base_addr_i & ~OffMask;
                    state_d   = (num_bursts_i == 32'd0) ? FINISH : WR_ADDR;
                end
            end
            WR_ADDR: if (aw_ready_i) begin
                beat_d  = '0;
                state_d = WR_DATA;
            end
            WR_DATA: if (w_ready_i) begin
                if (beat_q == LastBeat) state_d = WR_RESP;
                else                    beat_d  = beat_q + 9'd1;
            end
            WR_RESP: if (b_valid_i) begin
                err_hit  = b_resp_i != RespOkay;
                err_addr = addr_q;
                if (!last_burst) begin
                    state_d = WR_ADDR;
                    burst_d = burst_q + 32'd1;
                    addr_d  = addr_q + AxiAddrWidth'(BurstBytes);
                end else if (verify_q) begin
                    state_d = RD_ADDR;
                    burst_d = '0;
                    addr_d  = base_q;
                end else begin
                    state_d = FINISH;
                end
            end
            RD_ADDR: if (ar_ready_i) begin
                beat_d  = '0;
                state_d = RD_DATA;
            end
            RD_DATA: if (r_valid_i) begin
                // The counted beat, not r_last, closes the burst so a bad r_last cannot desync us.
                err_hit = (r_resp_i != RespOkay) || (r_data_i != pattern(seed_q, beat_addr)) ||
                          (r_last_i != (beat_q == LastBeat));
                if (beat_q != LastBeat) begin
                    beat_d = beat_q + 9'd1;
                end else if (last_burst) begin
                    state_d = FINISH;
                end else begin
                    state_d = RD_ADDR;
                    burst_d = burst_q + 32'd1;
                    addr_d  = addr_q + AxiAddrWidth'(BurstBytes);
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            burst_q <= '0;
            beat_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= state_d != IDLE;
            burst_q <= burst_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
        end
    end

    // Operation parameters are plain data: only meaningful after an accepted start.
    always_ff @(posedge clk_i) begin
        if (start_acc) begin
            base_q   <= base_addr_i & ~OffMask;
            num_q    <= num_bursts_i;
            seed_q   <= seed_i;
            verify_q <= verify_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            error_q     <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
        end else if (start_acc) begin
            error_q     <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
        end else if (err_hit) begin
            error_q <= 1'b1;
            if (err_cnt_q != '1)   err_cnt_q   <= err_cnt_q + 32'd1;
            if (err_cnt_q == '0)   first_err_q <= err_addr;
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = state_q == FINISH;
    assign error_o          = error_q;
    assign err_count_o      = err_cnt_q;
    assign first_err_addr_o = first_err_q;

    assign aw_id_o    = '0;
    assign aw_addr_o  = addr_q;
    assign aw_len_o   = 8'(BurstLen - 1);
    assign aw_size_o  = 3'(SizeLog2);
    assign aw_burst_o = 2'b01;
    assign aw_valid_o = state_q == WR_ADDR;

    assign w_data_o   = pattern(seed_q, beat_addr);
    assign w_strb_o   = '1;
    assign w_last_o   = (state_q == WR_DATA) && (beat_q == LastBeat);
    assign w_valid_o  = state_q == WR_DATA;
    assign b_ready_o  = state_q == WR_RESP;

    assign ar_id_o    = '0;
    assign ar_addr_o  = addr_q;
    assign ar_len_o   = 8'(BurstLen - 1);
    assign ar_size_o  = 3'(SizeLog2);
    assign ar_burst_o = 2'b01;
    assign ar_valid_o = state_q == RD_ADDR;
    assign r_ready_o  = state_q == RD_DATA;
endmodule
